updown_digit_pair: RTL

- Registered two-digit modulo up/down counter, e.g. seconds field: low digit mod 10, high digit mod 6.
- Consumes raw increment/decrement request levels from the button/debounce front end and converts each rising edge into one step.
- Ripples carry/borrow from the low digit into the high digit.
- Holds the counter state and reports wrap/limit events to the next stage (e.g. the minutes pair).

---
 rtl/updown_digit_pair.sv | 118 +++++++++++
 1 files changed

// File: rtl/updown_digit_pair.sv
// Two-digit modulo up/down counter (e.g. a seconds field) stepped by request edges,
// rippling carry/borrow from the low digit into the high digit and flagging end wraps.
module updown_digit_pair #(
  parameter int L_LO = 10,
  parameter int L_HI = 6,
  parameter int W_LO = $clog2(L_LO),
  parameter int W_HI = $clog2(L_HI),
  parameter bit SAT  = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic            inc_req,
  input  logic            dec_req,
  input  logic            load,
  input  logic [W_LO-1:0] load_lo,
  input  logic [W_HI-1:0] load_hi,
  output logic [W_LO-1:0] digit_lo,
  output logic [W_HI-1:0] digit_hi,
  output logic            wrap_up,
  output logic            wrap_dn,
  output logic            is_zero
);

  localparam logic [W_LO-1:0] LO_MAX = W_LO'(L_LO - 1);
  localparam logic [W_HI-1:0] HI_MAX = W_HI'(L_HI - 1);

  logic            r_inc_q;
  logic            r_dec_q;
  logic [W_LO-1:0] r_lo;
  logic [W_HI-1:0] r_hi;
  logic            r_wrap_up;
  logic            r_wrap_dn;

  logic            w_up_ev;
  logic            w_dn_ev;
  logic [W_LO-1:0] w_lo_nxt;
  logic [W_HI-1:0] w_hi_nxt;
  logic            w_wrap_up_nxt;
  logic            w_wrap_dn_nxt;

  function automatic logic [W_LO-1:0] clamp_lo(input logic [W_LO-1:0] v);
    return (v > LO_MAX) ? LO_MAX : v;
  endfunction

  function automatic logic [W_HI-1:0] clamp_hi(input logic [W_HI-1:0] v);
    return (v > HI_MAX) ? HI_MAX : v;
  endfunction

  assign w_up_ev = inc_req & ~r_inc_q;
  assign w_dn_ev = dec_req & ~r_dec_q;

  always_comb begin
    w_lo_nxt      = r_lo;
    w_hi_nxt      = r_hi;
    w_wrap_up_nxt = 1'b0;
    w_wrap_dn_nxt = 1'b0;
    if (load) begin
      w_lo_nxt = clamp_lo(load_lo);
      w_hi_nxt = clamp_hi(load_hi);
    end else if (en && (w_up_ev != w_dn_ev)) begin
      if (w_up_ev) begin
        if (r_lo != LO_MAX) begin
          w_lo_nxt = r_lo + W_LO'(1);
        end else if (r_hi != HI_MAX) begin
          w_lo_nxt = '0;
          w_hi_nxt = r_hi + W_HI'(1);
        end else begin
          // Full-scale: either hold (saturating) or roll over to 00.
          w_wrap_up_nxt = 1'b1;
          if (!SAT) begin
            w_lo_nxt = '0;
            w_hi_nxt = '0;
          end
        end
      end else begin
        if (r_lo != '0) begin
          w_lo_nxt = r_lo - W_LO'(1);
        end else if (r_hi != '0) begin
          w_lo_nxt = LO_MAX;
          w_hi_nxt = r_hi - W_HI'(1);
        end else begin
          w_wrap_dn_nxt = 1'b1;
          if (!SAT) begin
            w_lo_nxt = LO_MAX;
            w_hi_nxt = HI_MAX;
          end
        end
      end
    end
  end

  // Edge trackers come out of reset high so a level held through reset is not a step.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_inc_q   <= 1'b1;
      r_dec_q   <= 1'b1;
      r_lo      <= '0;
      r_hi      <= '0;
      r_wrap_up <= 1'b0;
      r_wrap_dn <= 1'b0;
    end else begin
      r_inc_q   <= inc_req;
      r_dec_q   <= dec_req;
      r_lo      <= w_lo_nxt;
      r_hi      <= w_hi_nxt;
      r_wrap_up <= w_wrap_up_nxt;
      r_wrap_dn <= w_wrap_dn_nxt;
    end
  end

  assign digit_lo = r_lo;
  assign digit_hi = r_hi;
  assign wrap_up  = r_wrap_up;
  assign wrap_dn  = r_wrap_dn;
  assign is_zero  = (r_lo == '0) && (r_hi == '0);

endmodule
